adc_spi_responder: RTL and testbench

SPI responder that emulates an ADC128S022-style 8-channel, 12-bit serial ADC. It sits on the far end of the `adc_capture` SPI link, either in simulation or on a second board. Every input is oversampled on clk25. It captures the 3-bit channel address from MOSI and shifts back the 12-bit value of the channel selected in the previous frame. Channel values come from an internal 8×12 register file loaded through a simple write port.

---
 rtl/adc_spi_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_adc_spi_responder.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// ADC128S022-style SPI responder: oversamples the SPI pins on clk25, captures the channel
// address from MOSI and shifts back the 12-bit register-file value selected by the previous frame.
module adc_spi_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [2:0]  RESET_ADDR  = 3'd0
) (
    input  logic        clk25,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_csn,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic        wr_en,
    input  logic [2:0]  wr_ch,
    input  logic [11:0] wr_data,
    output logic        frame_done,
    output logic        frame_err,
    output logic [2:0]  frame_addr,
    output logic [15:0] frame_count
);

    localparam int unsigned SyncMsb = SYNC_STAGES - 1;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_csn_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_hist;
    logic                   r_csn_hist;
    logic                   r_sclk_rise_ev;
    logic                   r_cs_fall_ev;
    logic                   r_cs_rise_ev;
    logic                   r_mosi_smp;

    logic                   w_sclk_rise;
    logic                   w_cs_fall;
    logic                   w_cs_rise;

    logic [11:0]            r_regfile [8];

    state_e                 r_state;
    state_e                 w_state_next;

    logic [4:0]             r_bit_cnt;
    logic [4:0]             w_bit_cnt_next;
    logic [15:0]            r_tx_shift;
    logic [15:0]            w_tx_shift_next;
    logic [2:0]             r_addr_sr;
    logic [2:0]             w_addr_sr_next;
    logic [2:0]             r_next_addr;
    logic [2:0]             w_next_addr_next;
    logic                   r_miso;
    logic                   w_miso_next;
    logic                   r_frame_done;
    logic                   w_frame_done_next;
    logic                   r_frame_err;
    logic                   w_frame_err_next;
    logic [2:0]             r_frame_addr;
    logic [2:0]             w_frame_addr_next;
    logic [15:0]            r_frame_count;
    logic [15:0]            w_frame_count_next;

    assign w_sclk_rise = r_sclk_sync[SyncMsb] & ~r_sclk_hist;
    assign w_cs_fall   = ~r_csn_sync[SyncMsb] & r_csn_hist;
    assign w_cs_rise   = r_csn_sync[SyncMsb] & ~r_csn_hist;

    // Events and MOSI are registered together so MOSI stays aligned with its SCLK rise.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_sclk_sync    <= '0;
            r_csn_sync     <= '0;
            r_mosi_sync    <= '0;
            r_sclk_hist    <= 1'b0;
            r_csn_hist     <= 1'b0;
            r_sclk_rise_ev <= 1'b0;
            r_cs_fall_ev   <= 1'b0;
            r_cs_rise_ev   <= 1'b0;
            r_mosi_smp     <= 1'b0;
        end else begin
            r_sclk_sync    <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_csn_sync     <= {r_csn_sync[SYNC_STAGES-2:0], spi_csn};
            r_mosi_sync    <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_hist    <= r_sclk_sync[SyncMsb];
            r_csn_hist     <= r_csn_sync[SyncMsb];
            r_sclk_rise_ev <= w_sclk_rise;
            r_cs_fall_ev   <= w_cs_fall;
            r_cs_rise_ev   <= w_cs_rise;
            r_mosi_smp     <= r_mosi_sync[SyncMsb];
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regfile[i] <= '0;
            end
        end else if (wr_en) begin
            r_regfile[wr_ch] <= wr_data;
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (r_cs_fall_ev) begin
                    w_state_next = StShift;
                end
            end
            StShift: begin
                if (r_cs_rise_ev) begin
                    w_state_next = StIdle;
                end else if (r_sclk_rise_ev && (r_bit_cnt == 5'd15)) begin
                    w_state_next = StHold;
                end
            end
            StHold: begin
                if (r_cs_rise_ev) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_bit_cnt_next     = r_bit_cnt;
        w_tx_shift_next    = r_tx_shift;
        w_addr_sr_next     = r_addr_sr;
        w_next_addr_next   = r_next_addr;
        w_miso_next        = r_miso;
        w_frame_done_next  = 1'b0;
        w_frame_err_next   = 1'b0;
        w_frame_addr_next  = r_frame_addr;
        w_frame_count_next = r_frame_count;
        unique case (r_state)
            StIdle: begin
                w_miso_next    = 1'b0;
                w_bit_cnt_next = '0;
                if (r_cs_fall_ev) begin
                    // Snapshot reads the pre-write value when a write lands on the same edge.
                    w_tx_shift_next = {4'b0000, r_regfile[r_next_addr]};
                    w_miso_next     = w_tx_shift_next[15];
                    w_addr_sr_next  = '0;
                end
            end
            StShift: begin
                if (r_cs_rise_ev) begin
                    w_frame_err_next = 1'b1;
                    w_miso_next      = 1'b0;
                    w_bit_cnt_next   = '0;
                end else if (r_sclk_rise_ev) begin
                    w_bit_cnt_next = r_bit_cnt + 5'd1;
                    if ((r_bit_cnt >= 5'd2) && (r_bit_cnt <= 5'd4)) begin
                        w_addr_sr_next = {r_addr_sr[1:0], r_mosi_smp};
                    end
                    w_tx_shift_next = {r_tx_shift[14:0], 1'b0};
                    w_miso_next     = w_tx_shift_next[15];
                    if (r_bit_cnt == 5'd15) begin
                        w_frame_done_next  = 1'b1;
                        w_next_addr_next   = w_addr_sr_next;
                        w_frame_addr_next  = w_addr_sr_next;
                        w_frame_count_next = r_frame_count + 16'd1;
                        w_miso_next        = 1'b0;
                    end
                end
            end
            StHold: begin
                w_miso_next = 1'b0;
            end
            default: begin
                w_miso_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_bit_cnt     <= '0;
            r_tx_shift    <= '0;
            r_addr_sr     <= '0;
            r_next_addr   <= RESET_ADDR;
            r_miso        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_addr  <= RESET_ADDR;
            r_frame_count <= '0;
        end else begin
            r_bit_cnt     <= w_bit_cnt_next;
            r_tx_shift    <= w_tx_shift_next;
            r_addr_sr     <= w_addr_sr_next;
            r_next_addr   <= w_next_addr_next;
            r_miso        <= w_miso_next;
            r_frame_done  <= w_frame_done_next;
            r_frame_err   <= w_frame_err_next;
            r_frame_addr  <= w_frame_addr_next;
            r_frame_count <= w_frame_count_next;
        end
    end

    assign spi_miso    = r_miso;
    assign frame_done  = r_frame_done;
    assign frame_err   = r_frame_err;
    assign frame_addr  = r_frame_addr;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: an SPI master model drives frames, a register-file model feeds a
// scoreboard of expected MISO words, and each scenario task checks its own results inline.
module tb_adc_spi_responder;

    logic        clk25 = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_ch = 3'd0;
    logic [11:0] wr_data = 12'd0;
    logic        spi_miso;
    logic        frame_done;
    logic        frame_err;
    logic [2:0]  frame_addr;
    logic [15:0] frame_count;

    adc_spi_responder #(
        .SYNC_STAGES(2),
        .RESET_ADDR (3'd0)
    ) dut (
        .clk25      (clk25),
        .rst        (rst),
        .spi_sclk   (spi_sclk),
        .spi_csn    (spi_csn),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_addr (frame_addr),
        .frame_count(frame_count)
    );

    always #20 clk25 = ~clk25;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;
    int err_seen = 0;

    always @(negedge clk25) begin
        if (frame_done) done_seen++;
        if (frame_err) err_seen++;
    end

    logic [11:0] m_rf [8];
    logic [2:0]  m_next;
    logic [2:0]  m_faddr;
    logic [15:0] m_count;
    logic [15:0] sb_q [$];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 12'd0;
        m_next  = 3'd0;
        m_faddr = 3'd0;
        m_count = 16'd0;
        sb_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk25);
        rst = 1'b1;
        repeat (3) @(negedge clk25);
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk25);
    endtask

    task automatic write_reg(input logic [2:0] ch, input logic [11:0] data);
        @(negedge clk25);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_data = data;
        @(negedge clk25);
        wr_en   = 1'b0;
        m_rf[ch] = data;
    endtask

    // Mode-0 master: MOSI/MISO change after the rise, sampled just before the next rise.
    task automatic run_frame(input logic [2:0] addr, input int n_rises, input int wr_bit,
                             input logic [2:0] wch, input logic [11:0] wdat, input bit probe,
                             output logic [15:0] word, output logic [3:0] extra);
        logic [15:0] din;
        logic [15:0] snap;
        din   = {2'b00, addr, 11'd0};
        word  = 16'd0;
        extra = 4'd0;
        snap  = {4'h0, m_rf[m_next]};
        if (n_rises >= 16) sb_q.push_back(snap);
        @(negedge clk25);
        spi_csn = 1'b0;
        repeat (6) @(negedge clk25);
        for (int k = 1; k <= n_rises; k++) begin
            if (k == wr_bit) begin
                wr_en   = 1'b1;
                wr_ch   = wch;
                wr_data = wdat;
                @(negedge clk25);
                wr_en = 1'b0;
                m_rf[wch] = wdat;
            end
            spi_mosi = (k <= 16) ? din[16-k] : 1'b0;
            @(negedge clk25);
            if (k <= 16) word[16-k] = spi_miso;
            else extra[k-17] = spi_miso;
            spi_sclk = 1'b1;
            if (probe && k == 4) begin
                repeat (3) @(posedge clk25);
                #1;
                n_checks++;
                if (spi_miso !== snap[12]) begin
                    n_errors++;
                    $display("FAIL latency_early: miso=%b required=%b", spi_miso, snap[12]);
                end
                @(posedge clk25);
                #1;
                n_checks++;
                if (spi_miso !== snap[11]) begin
                    n_errors++;
                    $display("FAIL latency_edge4: miso=%b required=%b", spi_miso, snap[11]);
                end
                @(negedge clk25);
            end else begin
                repeat (4) @(negedge clk25);
            end
            spi_sclk = 1'b0;
            repeat (3) @(negedge clk25);
        end
        repeat (6) @(negedge clk25);
        spi_csn  = 1'b1;
        spi_mosi = 1'b0;
        repeat (10) @(negedge clk25);
        if (n_rises >= 16) begin
            m_next  = addr;
            m_faddr = addr;
            m_count = m_count + 16'd1;
        end
    endtask

    task automatic test_reset();
        logic [15:0] w, exp;
        logic [3:0]  x;
        int          d0;
        rst = 1'b1;
        repeat (3) @(negedge clk25);
        rst = 1'b0;
        model_reset();
        repeat (5) @(negedge clk25);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({spi_miso, frame_done, frame_err, frame_addr, frame_count} !== {3'b000, 3'd0, 16'd0}) begin
            n_errors++;
            $display("FAIL reset_outputs: miso=%b done=%b err=%b addr=%0d count=%0d required all 0",
                     spi_miso, frame_done, frame_err, frame_addr, frame_count);
        end
        repeat (2) @(negedge clk25);
        rst = 1'b0;
        repeat (3) @(negedge clk25);
        d0 = done_seen;
        run_frame(3'd5, 16, 0, 3'd0, 12'd0, 1'b0, w, x);
        exp = sb_q.pop_front();
        n_checks++;
        if (w !== 16'h0000 || w !== exp) begin
            n_errors++;
            $display("FAIL reset_frame_word: got=%h required=%h", w, exp);
        end
        n_checks++;
        if (done_seen - d0 !== 1) begin
            n_errors++;
            $display("FAIL reset_frame_done: pulses=%0d required=1", done_seen - d0);
        end
        n_checks++;
        if (frame_addr !== 3'd5 || frame_count !== 16'd1) begin
            n_errors++;
            $display("FAIL reset_frame_status: addr=%0d count=%0d required 5/1", frame_addr, frame_count);
        end
    endtask

    task automatic test_prev_channel();
        logic [15:0] w, exp;
        logic [3:0]  x;
        do_reset();
        write_reg(3'd0, 12'hABC);
        write_reg(3'd5, 12'h123);
        run_frame(3'd5, 16, 0, 3'd0, 12'd0, 1'b0, w, x);
        exp = sb_q.pop_front();
        n_checks++;
        if (w !== 16'h0ABC || w !== exp) begin
            n_errors++;
            $display("FAIL prev_ch_word0: got=%h required=%h", w, exp);
        end
        n_checks++;
        if (frame_addr !== 3'd5) begin
            n_errors++;
            $display("FAIL prev_ch_addr: got=%0d required=5", frame_addr);
        end
        run_frame(3'd0, 16, 0, 3'd0, 12'd0, 1'b0, w, x);
        exp = sb_q.pop_front();
        n_checks++;
        if (w !== 16'h0123 || w !== exp) begin
            n_errors++;
            $display("FAIL prev_ch_word1: got=%h required=%h", w, exp);
        end
    endtask

    task automatic test_short_frame();
        logic [15:0] w, exp, cnt0;
        logic [3:0]  x;
        int          e0, d0;
        run_frame(3'd5, 16, 0, 3'd0, 12'd0, 1'b0, w, x);
        exp = sb_q.pop_front();
        n_checks++;
        if (w !== exp) begin
            n_errors++;
            $display("FAIL short_pre_word: got=%h required=%h", w, exp);
        end
        cnt0 = m_count;
        e0 = err_seen;
        d0 = done_seen;
        run_frame(3'd7, 8, 0, 3'd0, 12'd0, 1'b0, w, x);
        n_checks++;
        if (err_seen - e0 !== 1 || done_seen - d0 !== 0) begin
            n_errors++;
            $display("FAIL short_pulses: err=%0d done=%0d required 1/0", err_seen - e0, done_seen - d0);
        end
        n_checks++;
        if (frame_count !== cnt0 || frame_addr !== 3'd5) begin
            n_errors++;
            $display("FAIL short_status: count=%0d addr=%0d required %0d/5", frame_count, frame_addr, cnt0);
        end
        run_frame(3'd2, 16, 0, 3'd0, 12'd0, 1'b0, w, x);
        exp = sb_q.pop_front();
        n_checks++;
        if (w !== 16'h0123 || w !== exp) begin
            n_errors++;
            $display("FAIL short_post_word: got=%h required=%h", w, exp);
        end
    endtask

    task automatic test_mid_frame_write();
        logic [15:0] w, exp;
        logic [3:0]  x;
        write_reg(3'd2, 12'h456);
        run_frame(3'd3, 16, 6, 3'd2, 12'hFFF, 1'b0, w, x);
        exp = sb_q.pop_front();
        n_checks++;
        if (w !== 16'h0456 || w !== exp) begin
            n_errors++;
            $display("FAIL midwrite_old: got=%h required=%h", w, exp);
        end
        write_reg(3'd3, 12'h800);
        run_frame(3'd2, 16, 0, 3'd0, 12'd0, 1'b0, w, x);
        exp = sb_q.pop_front();
        n_checks++;
        if (w !== 16'h0800 || w !== exp) begin
            n_errors++;
            $display("FAIL midwrite_ch3: got=%h required=%h", w, exp);
        end
    endtask

    task automatic test_latency();
        logic [15:0] w, exp;
        logic [3:0]  x;
        write_reg(3'd2, 12'hFFF);
        run_frame(3'd1, 16, 0, 3'd0, 12'd0, 1'b1, w, x);
        exp = sb_q.pop_front();
        n_checks++;
        if (w !== 16'h0FFF || w !== exp) begin
            n_errors++;
            $display("FAIL latency_word: got=%h required=%h", w, exp);
        end
    endtask

    task automatic test_overlong();
        logic [15:0] w, exp, cnt0;
        logic [3:0]  x;
        int          d0;
        write_reg(3'd1, 12'h5A5);
        cnt0 = m_count;
        d0 = done_seen;
        run_frame(3'd4, 20, 0, 3'd0, 12'd0, 1'b0, w, x);
        exp = sb_q.pop_front();
        n_checks++;
        if (w !== 16'h05A5 || w !== exp) begin
            n_errors++;
            $display("FAIL overlong_word: got=%h required=%h", w, exp);
        end
        n_checks++;
        if (x !== 4'b0000) begin
            n_errors++;
            $display("FAIL overlong_tail: miso bits=%b required=0000", x);
        end
        n_checks++;
        if (done_seen - d0 !== 1 || frame_count !== cnt0 + 16'd1 || frame_addr !== 3'd4) begin
            n_errors++;
            $display("FAIL overlong_status: done=%0d count=%0d addr=%0d required 1/%0d/4",
                     done_seen - d0, frame_count, frame_addr, cnt0 + 16'd1);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] w, exp;
        logic [3:0]  x;
        write_reg(m_next, 12'hFFF);
        @(negedge clk25);
        spi_csn = 1'b0;
        repeat (6) @(negedge clk25);
        for (int k = 1; k <= 5; k++) begin
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk25);
            spi_sclk = 1'b0;
            repeat (4) @(negedge clk25);
        end
        n_checks++;
        if (spi_miso !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_before: miso=%b required=1", spi_miso);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (spi_miso !== 1'b0 || frame_count !== 16'd0 || frame_addr !== 3'd0) begin
            n_errors++;
            $display("FAIL midrst_state: miso=%b count=%0d addr=%0d required 0/0/0",
                     spi_miso, frame_count, frame_addr);
        end
        repeat (2) @(negedge clk25);
        spi_csn = 1'b1;
        rst = 1'b0;
        model_reset();
        repeat (6) @(negedge clk25);
        write_reg(3'd0, 12'h3C3);
        write_reg(3'd6, 12'h111);
        run_frame(3'd6, 16, 0, 3'd0, 12'd0, 1'b0, w, x);
        exp = sb_q.pop_front();
        n_checks++;
        if (w !== 16'h03C3 || w !== exp) begin
            n_errors++;
            $display("FAIL midrst_frame: got=%h required=%h", w, exp);
        end
    endtask

    task automatic test_link();
        logic [15:0] w, exp;
        logic [3:0]  x;
        logic [2:0]  a;
        for (int i = 0; i < 8; i++) begin
            write_reg(3'(i), 12'($urandom_range(0, 4095)) ^ 12'(i * 12'h111));
        end
        for (int i = 0; i < 40; i++) begin
            a = 3'(i * 3);
            run_frame(a, 16, 0, 3'd0, 12'd0, 1'b0, w, x);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL link_empty: frame=%0d scoreboard empty", i);
            end else begin
                exp = sb_q.pop_front();
                n_checks++;
                if (w !== exp) begin
                    n_errors++;
                    $display("FAIL link_word: frame=%0d got=%h required=%h", i, w, exp);
                end
            end
        end
        n_checks++;
        if (frame_count !== m_count || frame_addr !== m_faddr) begin
            n_errors++;
            $display("FAIL link_status: count=%0d addr=%0d required %0d/%0d",
                     frame_count, frame_addr, m_count, m_faddr);
        end
    endtask

    initial begin
        test_reset();
        test_prev_channel();
        test_short_frame();
        test_mid_frame_write();
        test_latency();
        test_overlong();
        test_reset_midframe();
        test_link();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
